// File: rtl/i2c_wb_sequencer_pkg.sv
// rtl/i2c_wb_sequencer_pkg.sv - shared constants, state and error types for the I2C sequencer
package i2c_seq_pkg;

  localparam logic [2:0] ADR_PRERLO = 3'd0;
  localparam logic [2:0] ADR_PRERHI = 3'd1;
  localparam logic [2:0] ADR_CTR    = 3'd2;
  localparam logic [2:0] ADR_TXR    = 3'd3;
  localparam logic [2:0] ADR_RXR    = 3'd3;
  localparam logic [2:0] ADR_CR     = 3'd4;
  localparam logic [2:0] ADR_SR     = 3'd4;

  localparam int CR_STA = 7;
  localparam int CR_STO = 6;
  localparam int CR_RD  = 5;
  localparam int CR_WR  = 4;
  localparam int CR_ACK = 3;

  localparam int SR_RXACK = 7;
  localparam int SR_AL    = 5;
  localparam int SR_TIP   = 1;

  localparam logic [7:0] CTR_EN           = 8'h80;
  localparam logic [7:0] CMD_START_WR     = 8'((1 << CR_STA) | (1 << CR_WR));
  localparam logic [7:0] CMD_WR           = 8'(1 << CR_WR);
  localparam logic [7:0] CMD_WR_STOP      = 8'((1 << CR_STO) | (1 << CR_WR));
  localparam logic [7:0] CMD_RD_NACK_STOP = 8'((1 << CR_STO) | (1 << CR_RD) | (1 << CR_ACK));
  localparam logic [7:0] CMD_STOP         = 8'(1 << CR_STO);

  typedef enum logic [3:0] {
    ST_INIT_PL, ST_INIT_PH, ST_INIT_CTR, ST_IDLE, ST_TXR, ST_CR,
    ST_POLL, ST_ABORT, ST_RXR, ST_SETTLE, ST_RESP
  } state_e;

  typedef enum logic [1:0] {
    ERR_OK      = 2'b00,
    ERR_NACK    = 2'b01,
    ERR_AL      = 2'b10,
    ERR_TIMEOUT = 2'b11
  } rsp_err_e;

  // Command byte for a byte phase: writes use phases 0..2, reads 0..3
  function automatic logic [7:0] phase_cr(input logic rw, input logic [1:0] phase);
    case (phase)
      2'd0:    return CMD_START_WR;
      2'd1:    return CMD_WR;
      2'd2:    return rw ? CMD_START_WR : CMD_WR_STOP;
      default: return CMD_RD_NACK_STOP;
    endcase
  endfunction

endpackage

// File: rtl/i2c_wb_sequencer_if.sv
// rtl/i2c_wb_sequencer_if.sv - Wishbone link between the sequencer and the I2C core
interface i2c_wb_sequencer_if;
  logic [2:0] wb_adr_o;
  logic [7:0] wb_dat_o;
  logic [7:0] wb_dat_i;
  logic       wb_we_o;
  logic       wb_stb_o;
  logic       wb_cyc_o;
  logic       wb_ack_i;

  modport master (
    output wb_adr_o, wb_dat_o, wb_we_o, wb_stb_o, wb_cyc_o,
    input  wb_dat_i, wb_ack_i
  );

  modport slave (
    input  wb_adr_o, wb_dat_o, wb_we_o, wb_stb_o, wb_cyc_o,
    output wb_dat_i, wb_ack_i
  );
endinterface

// File: rtl/i2c_wb_sequencer_wb_single_master.sv
// rtl/i2c_wb_sequencer_wb_single_master.sv - single non-pipelined Wishbone access engine
module wb_single_master
  import i2c_seq_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       start_i,
  input  logic [2:0] adr_i,
  input  logic       we_i,
  input  logic [7:0] wdat_i,
  output logic       done_o,
  output logic [7:0] rdat_o,
  i2c_wb_sequencer_if.master wb
);

  logic       cyc_q;
  logic       we_q;
  logic [2:0] adr_q;
  logic [7:0] dat_q;
  logic       done_q;
  logic [7:0] rdat_q;

  // Launch on start, hold until ack, then pulse done; the done cycle blocks a relaunch so accesses never abut
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cyc_q  <= 1'b0;
      we_q   <= 1'b0;
      adr_q  <= 3'd0;
      dat_q  <= 8'h00;
      done_q <= 1'b0;
      rdat_q <= 8'h00;
    end else begin
      done_q <= 1'b0;
      if (cyc_q) begin
        if (wb.wb_ack_i) begin
          cyc_q  <= 1'b0;
          done_q <= 1'b1;
          if (!we_q) rdat_q <= wb.wb_dat_i;
        end
      end else if (start_i && !done_q) begin
        cyc_q <= 1'b1;
        adr_q <= adr_i;
        we_q  <= we_i;
        dat_q <= we_i ? wdat_i : 8'h00;
      end
    end
  end

  assign wb.wb_cyc_o = cyc_q;
  assign wb.wb_stb_o = cyc_q;
  assign wb.wb_we_o  = we_q;
  assign wb.wb_adr_o = adr_q;
  assign wb.wb_dat_o = dat_q;
  assign done_o      = done_q;
  assign rdat_o      = rdat_q;

endmodule

// File: rtl/i2c_wb_sequencer.sv
// rtl/i2c_wb_sequencer.sv - init and single-register I2C transfer sequencer over Wishbone
module i2c_wb_sequencer
  import i2c_seq_pkg::*;
#(
  parameter logic [15:0] PRESCALE   = 16'd99,
  parameter int          POLL_LIMIT = 1024
) (
  input  logic       wb_clk_i,
  input  logic       wb_rst_i,
  i2c_wb_sequencer_if.master wb,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic       req_rw,
  input  logic [6:0] req_dev,
  input  logic [7:0] req_reg,
  input  logic [7:0] req_wdata,
  output logic       rsp_valid,
  output logic [7:0] rsp_rdata,
  output logic [1:0] rsp_err
);

  localparam int PW = $clog2(POLL_LIMIT + 1);

  state_e     state_q, state_d;
  logic [1:0] phase_q, phase_d;
  logic [PW-1:0] poll_q, poll_d;
  rsp_err_e   err_q, err_d;
  logic [7:0] rdata_q, rdata_d;
  logic       rw_q, rw_d;
  logic [6:0] dev_q, dev_d;
  logic [7:0] reg_q, reg_d;
  logic [7:0] wdata_q, wdata_d;

  logic       start;
  logic [2:0] adr;
  logic       we;
  logic [7:0] wdat;
  logic       done;
  logic [7:0] rdat;

  logic [7:0] cur_cr, nxt_cr, cur_txr;
  logic       last_phase;

  assign cur_cr     = phase_cr(rw_q, phase_q);
  assign nxt_cr     = phase_cr(rw_q, phase_q + 2'd1);
  assign last_phase = (phase_q == (rw_q ? 2'd3 : 2'd2));

  // TXR byte of the current phase; the read-data phase writes no TXR
  always_comb begin
    cur_txr = 8'h00;
    case (phase_q)
      2'd0:    cur_txr = {dev_q, 1'b0};
      2'd1:    cur_txr = reg_q;
      2'd2:    cur_txr = rw_q ? {dev_q, 1'b1} : wdata_q;
      default: cur_txr = 8'h00;
    endcase
  end

  wb_single_master u_wb (
    .clk_i  (wb_clk_i),
    .rst_i  (wb_rst_i),
    .start_i(start),
    .adr_i  (adr),
    .we_i   (we),
    .wdat_i (wdat),
    .done_o (done),
    .rdat_o (rdat),
    .wb     (wb)
  );

  // State and latched-request registers
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q <= ST_INIT_PL;
      phase_q <= 2'd0;
      poll_q  <= '0;
      err_q   <= ERR_OK;
      rdata_q <= 8'h00;
      rw_q    <= 1'b0;
      dev_q   <= 7'd0;
      reg_q   <= 8'h00;
      wdata_q <= 8'h00;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      poll_q  <= poll_d;
      err_q   <= err_d;
      rdata_q <= rdata_d;
      rw_q    <= rw_d;
      dev_q   <= dev_d;
      reg_q   <= reg_d;
      wdata_q <= wdata_d;
    end
  end

  // Next state: advance on each access done, decide the outcome from SR once TIP clears
  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    poll_d  = poll_q;
    err_d   = err_q;
    rdata_d = rdata_q;
    rw_d    = rw_q;
    dev_d   = dev_q;
    reg_d   = reg_q;
    wdata_d = wdata_q;
    case (state_q)
      ST_INIT_PL:  if (done) state_d = ST_INIT_PH;
      ST_INIT_PH:  if (done) state_d = ST_INIT_CTR;
      ST_INIT_CTR: if (done) state_d = ST_IDLE;
      ST_IDLE: begin
        if (req_valid) begin
          rw_d    = req_rw;
          dev_d   = req_dev;
          reg_d   = req_reg;
          wdata_d = req_wdata;
          phase_d = 2'd0;
          err_d   = ERR_OK;
          rdata_d = 8'h00;
          state_d = ST_TXR;
        end
      end
      ST_TXR: if (done) state_d = ST_CR;
      ST_CR: begin
        if (done) begin
          poll_d  = '0;
          state_d = ST_POLL;
        end
      end
      ST_POLL: begin
        if (done) begin
          poll_d = poll_q + 1'b1;
          if (rdat[SR_TIP]) begin
            if (poll_q == PW'(POLL_LIMIT - 1)) begin
              err_d   = ERR_TIMEOUT;
              state_d = ST_ABORT;
            end
          end else if (rdat[SR_AL]) begin
            err_d   = ERR_AL;
            state_d = ST_SETTLE;
          end else if (rdat[SR_RXACK] && cur_cr[CR_WR]) begin
            err_d   = ERR_NACK;
            state_d = ST_ABORT;
          end else if (last_phase) begin
            state_d = rw_q ? ST_RXR : ST_SETTLE;
          end else begin
            phase_d = phase_q + 2'd1;
            state_d = nxt_cr[CR_RD] ? ST_CR : ST_TXR;
          end
        end
      end
      ST_ABORT: if (done) state_d = ST_SETTLE;
      ST_RXR: begin
        if (done) begin
          rdata_d = rdat;
          state_d = ST_SETTLE;
        end
      end
      ST_SETTLE: state_d = ST_RESP;
      ST_RESP:   state_d = ST_IDLE;
      default:   state_d = ST_INIT_PL;
    endcase
  end

  // Outputs: access request per state, host handshake and response
  always_comb begin
    start     = 1'b0;
    adr       = 3'd0;
    we        = 1'b0;
    wdat      = 8'h00;
    req_ready = 1'b0;
    rsp_valid = 1'b0;
    rsp_rdata = 8'h00;
    rsp_err   = 2'b00;
    case (state_q)
      ST_INIT_PL:  begin start = 1'b1; adr = ADR_PRERLO; we = 1'b1; wdat = PRESCALE[7:0];  end
      ST_INIT_PH:  begin start = 1'b1; adr = ADR_PRERHI; we = 1'b1; wdat = PRESCALE[15:8]; end
      ST_INIT_CTR: begin start = 1'b1; adr = ADR_CTR;    we = 1'b1; wdat = CTR_EN;         end
      ST_IDLE:     req_ready = 1'b1;
      ST_TXR:      begin start = 1'b1; adr = ADR_TXR; we = 1'b1; wdat = cur_txr;  end
      ST_CR:       begin start = 1'b1; adr = ADR_CR;  we = 1'b1; wdat = cur_cr;   end
      ST_POLL:     begin start = 1'b1; adr = ADR_SR; end
      ST_ABORT:    begin start = 1'b1; adr = ADR_CR;  we = 1'b1; wdat = CMD_STOP; end
      ST_RXR:      begin start = 1'b1; adr = ADR_RXR; end
      ST_RESP: begin
        rsp_valid = 1'b1;
        rsp_rdata = rdata_q;
        rsp_err   = err_q;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_i2c_wb_sequencer.sv
// tb/tb_i2c_wb_sequencer.sv - bench with I2C core/slave stub and transaction-level expectation model
module tb_i2c_wb_sequencer;

  localparam int LIMIT     = 8;
  localparam int TIP_POLLS = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       req_valid = 1'b0;
  logic       req_ready;
  logic       req_rw = 1'b0;
  logic [6:0] req_dev = 7'd0;
  logic [7:0] req_reg = 8'h00;
  logic [7:0] req_wdata = 8'h00;
  logic       rsp_valid;
  logic [7:0] rsp_rdata;
  logic [1:0] rsp_err;

  i2c_wb_sequencer_if bus ();

  i2c_wb_sequencer #(.PRESCALE(16'd99), .POLL_LIMIT(LIMIT)) dut (
    .wb_clk_i (clk),
    .wb_rst_i (rst),
    .wb       (bus),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_rw   (req_rw),
    .req_dev  (req_dev),
    .req_reg  (req_reg),
    .req_wdata(req_wdata),
    .rsp_valid(rsp_valid),
    .rsp_rdata(rsp_rdata),
    .rsp_err  (rsp_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // I2C core register stub with a behavioural slave at 0x50
  logic       ack_r = 1'b0;
  logic [7:0] rd_r = 8'h00;
  logic [7:0] prer_lo = 8'h00, prer_hi = 8'h00, ctr = 8'h00, txr = 8'h00, rxr = 8'h00, last_cr = 8'h00;
  logic       core_rxack = 1'b0, bus_busy = 1'b0, addressed = 1'b0, rd_dir = 1'b0, stretch = 1'b0;
  int         tip_left = 0, idx = 0, sr_reads = 0, sr_reads_last = 0;
  int         starts = 0, rep_starts = 0, stops = 0, cr_writes = 0;
  logic [7:0] ptr = 8'h00;
  logic [7:0] slv_mem [256];

  assign bus.wb_ack_i = ack_r;
  assign bus.wb_dat_i = rd_r;

  initial for (int i = 0; i < 256; i++) slv_mem[i] = 8'h00;

  always @(posedge clk) begin
    if (rst) begin
      ack_r <= 1'b0;
      bus_busy = 1'b0; tip_left = 0; prer_lo = 8'h00; prer_hi = 8'h00; ctr = 8'h00;
    end else if (bus.wb_cyc_o && bus.wb_stb_o && !ack_r) begin
      ack_r <= 1'b1;
      if (bus.wb_adr_o == 3'd4)      rd_r <= {core_rxack, 5'b00000, (tip_left != 0), 1'b0};
      else if (bus.wb_adr_o == 3'd3) rd_r <= rxr;
      else                           rd_r <= 8'h00;
    end else if (bus.wb_cyc_o && bus.wb_stb_o && ack_r) begin
      ack_r <= 1'b0;
      if (bus.wb_we_o) begin
        case (bus.wb_adr_o)
          3'd0: prer_lo = bus.wb_dat_o;
          3'd1: prer_hi = bus.wb_dat_o;
          3'd2: ctr = bus.wb_dat_o;
          3'd3: txr = bus.wb_dat_o;
          3'd4: begin
            last_cr = bus.wb_dat_o;
            cr_writes++;
            sr_reads_last = sr_reads;
            sr_reads = 0;
            if (last_cr[7]) begin
              if (bus_busy) rep_starts++;
              starts++;
              bus_busy = 1'b1;
            end
            if (last_cr[4]) begin
              if (last_cr[7]) begin
                addressed = (txr[7:1] == 7'h50);
                rd_dir = txr[0];
                idx = 0;
              end else if (addressed && !rd_dir) begin
                if (idx == 0) ptr = txr;
                else begin slv_mem[ptr] = txr; ptr = ptr + 8'd1; end
                idx++;
              end
              core_rxack = !addressed;
            end
            if (last_cr[5]) begin
              rxr = addressed ? slv_mem[ptr] : 8'hFF;
              ptr = ptr + 8'd1;
            end
            if (last_cr[6]) begin stops++; bus_busy = 1'b0; end
            tip_left = stretch ? 1000000 : TIP_POLLS;
          end
          default: ;
        endcase
      end else if (bus.wb_adr_o == 3'd4) begin
        sr_reads++;
        if (tip_left > 0) tip_left--;
      end
    end else begin
      ack_r <= 1'b0;
    end
  end

  // Expectation model: ordered bus accesses and responses derived from the request
  typedef struct packed { logic we; logic [2:0] adr; logic [7:0] dat; } acc_t;
  typedef struct packed { logic [1:0] err; logic [7:0] rdata; } rsp_t;
  acc_t exp_q [$];
  rsp_t rsp_q [$];
  logic [7:0] golden [256];
  initial for (int i = 0; i < 256; i++) golden[i] = 8'h00;

  task automatic push(input logic w, input logic [2:0] a, input logic [7:0] d);
    acc_t e;
    e.we = w; e.adr = a; e.dat = d;
    exp_q.push_back(e);
  endtask

  task automatic push_rsp(input logic [1:0] e, input logic [7:0] d);
    rsp_t r;
    r.err = e; r.rdata = d;
    rsp_q.push_back(r);
  endtask

  task automatic exp_init();
    push(1'b1, 3'd0, 8'h63);
    push(1'b1, 3'd1, 8'h00);
    push(1'b1, 3'd2, 8'h80);
  endtask

  task automatic exp_req(input logic rw, input logic [6:0] dev, input logic [7:0] rg,
                         input logic [7:0] wd, input logic stretched);
    logic [7:0] tb [4];
    logic [7:0] cb [4];
    int n;
    tb[0] = {dev, 1'b0};            cb[0] = 8'h90;
    tb[1] = rg;                     cb[1] = 8'h10;
    tb[2] = rw ? {dev, 1'b1} : wd;  cb[2] = rw ? 8'h90 : 8'h50;
    tb[3] = 8'h00;                  cb[3] = 8'h68;
    n = rw ? 4 : 3;
    for (int p = 0; p < n; p++) begin
      if (!cb[p][5]) push(1'b1, 3'd3, tb[p]);
      push(1'b1, 3'd4, cb[p]);
      if (stretched) begin
        repeat (LIMIT) push(1'b0, 3'd4, 8'h00);
        push(1'b1, 3'd4, 8'h40);
        push_rsp(2'b11, 8'h00);
        return;
      end
      repeat (TIP_POLLS + 1) push(1'b0, 3'd4, 8'h00);
      if (p == 0 && dev != 7'h50) begin
        push(1'b1, 3'd4, 8'h40);
        push_rsp(2'b01, 8'h00);
        return;
      end
    end
    if (rw) begin
      push(1'b0, 3'd3, 8'h00);
      push_rsp(2'b00, golden[rg]);
    end else begin
      golden[rg] = wd;
      push_rsp(2'b00, 8'h00);
    end
  endtask

  // Compare process: every completed access, bus hold rules, and every response
  logic       prev_cyc = 1'b0, prev_ack = 1'b0, prev_we = 1'b0;
  logic [2:0] prev_adr = 3'd0;
  logic [7:0] prev_dat = 8'h00;
  logic [1:0] last_err = 2'b00;
  logic [7:0] last_rdata = 8'h00;
  int         rsp_seen = 0;

  always @(negedge clk) begin
    if (rst) begin
      prev_cyc = 1'b0;
      prev_ack = 1'b0;
    end else begin
      acc_t e;
      rsp_t r;
      chk("stb_eq_cyc", bus.wb_stb_o, bus.wb_cyc_o);
      if (bus.wb_cyc_o && prev_cyc && !prev_ack)
        chk("bus_hold", {bus.wb_we_o, bus.wb_adr_o, bus.wb_dat_o}, {prev_we, prev_adr, prev_dat});
      if (bus.wb_cyc_o && ack_r) begin
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL wb_unexpected: got adr %0h we %0b dat %0h expected no access",
                   bus.wb_adr_o, bus.wb_we_o, bus.wb_dat_o);
        end else begin
          e = exp_q.pop_front();
          chk("wb_we", bus.wb_we_o, e.we);
          chk("wb_adr", bus.wb_adr_o, e.adr);
          if (e.we) chk("wb_dat", bus.wb_dat_o, e.dat);
        end
      end
      if (rsp_valid) begin
        rsp_seen++;
        last_err = rsp_err;
        last_rdata = rsp_rdata;
        if (rsp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL rsp_unexpected: got err %0h rdata %0h expected no response", rsp_err, rsp_rdata);
        end else begin
          r = rsp_q.pop_front();
          chk("rsp_err", rsp_err, r.err);
          chk("rsp_rdata", rsp_rdata, r.rdata);
        end
      end
      prev_cyc = bus.wb_cyc_o;
      prev_ack = ack_r;
      prev_we  = bus.wb_we_o;
      prev_adr = bus.wb_adr_o;
      prev_dat = bus.wb_dat_o;
    end
  end

  task automatic wait_ready(input string name);
    int n;
    for (n = 0; n < 500 && !req_ready; n++) begin @(posedge clk); #1; end
    chk(name, req_ready, 1'b1);
  endtask

  task automatic do_req(input logic rw, input logic [6:0] dev, input logic [7:0] rg,
                        input logic [7:0] wd, input logic poke);
    int n;
    wait_ready("ready_before_req");
    exp_req(rw, dev, rg, wd, stretch);
    req_rw = rw; req_dev = dev; req_reg = rg; req_wdata = wd; req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    chk("ready_falls_on_accept", req_ready, 1'b0);
    if (poke) begin
      repeat (4) begin @(posedge clk); #1; end
      req_reg = 8'h77; req_valid = 1'b1;
      @(posedge clk); #1;
      req_valid = 1'b0;
    end
    for (n = 0; n < 3000 && !rsp_valid; n++) begin @(posedge clk); #1; end
    chk("rsp_arrives", rsp_valid, 1'b1);
    @(posedge clk); #1;
    chk("rsp_one_cycle", rsp_valid, 1'b0);
    chk("ready_after_rsp", req_ready, 1'b1);
  endtask

  initial begin
    int n, base_stops, base_rep, base_cr, base_rsp;
    exp_init();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_cyc", bus.wb_cyc_o, 1'b0);
    chk("rst_stb", bus.wb_stb_o, 1'b0);
    chk("rst_we", bus.wb_we_o, 1'b0);
    chk("rst_adr", bus.wb_adr_o, 3'd0);
    chk("rst_dat", bus.wb_dat_o, 8'h00);
    chk("rst_ready", req_ready, 1'b0);
    chk("rst_rsp_valid", rsp_valid, 1'b0);
    chk("rst_rsp_rdata", rsp_rdata, 8'h00);
    chk("rst_rsp_err", rsp_err, 2'b00);
    rst = 1'b0;

    wait_ready("ready_after_init");
    chk("init_prerlo", prer_lo, 8'h63);
    chk("init_prerhi", prer_hi, 8'h00);
    chk("init_ctr", ctr, 8'h80);

    base_stops = stops;
    do_req(1'b0, 7'h50, 8'h12, 8'hA5, 1'b1);
    chk("wr_slave_mem", slv_mem[8'h12], 8'hA5);
    chk("wr_stop_seen", stops - base_stops, 1);
    chk("wr_err_literal", last_err, 2'b00);

    base_rep = rep_starts;
    do_req(1'b1, 7'h50, 8'h12, 8'h00, 1'b0);
    chk("rd_rep_start", rep_starts - base_rep, 1);
    chk("rd_data_literal", last_rdata, 8'hA5);
    chk("rd_err_literal", last_err, 2'b00);

    do_req(1'b0, 7'h33, 8'h01, 8'h5A, 1'b0);
    chk("nack_err_literal", last_err, 2'b01);
    chk("nack_rdata_literal", last_rdata, 8'h00);
    chk("nack_stop_cr", last_cr, 8'h40);

    stretch = 1'b1;
    base_stops = stops;
    do_req(1'b0, 7'h50, 8'h20, 8'h11, 1'b0);
    stretch = 1'b0;
    chk("to_sr_reads", sr_reads_last, LIMIT);
    chk("to_err_literal", last_err, 2'b11);
    chk("to_stop_cr", last_cr, 8'h40);
    chk("to_stop_seen", stops - base_stops, 1);
    chk("to_mem_untouched", slv_mem[8'h20], 8'h00);

    wait_ready("ready_before_rst_test");
    base_cr = cr_writes;
    base_rsp = rsp_seen;
    exp_req(1'b1, 7'h50, 8'h12, 8'h00, 1'b0);
    req_rw = 1'b1; req_dev = 7'h50; req_reg = 8'h12; req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    for (n = 0; n < 500 && cr_writes < base_cr + 2; n++) begin @(posedge clk); #1; end
    chk("rst_test_second_xfer", cr_writes - base_cr, 2);
    for (n = 0; n < 50 && !bus.wb_cyc_o; n++) begin @(posedge clk); #1; end
    chk("rst_test_cyc_busy", bus.wb_cyc_o, 1'b1);
    exp_q.delete();
    rsp_q.delete();
    exp_init();
    rst = 1'b1;
    @(posedge clk); #1;
    chk("midrst_cyc_low", bus.wb_cyc_o, 1'b0);
    chk("midrst_stb_low", bus.wb_stb_o, 1'b0);
    rst = 1'b0;
    wait_ready("ready_after_midrst");
    chk("reinit_prerlo", prer_lo, 8'h63);
    chk("reinit_ctr", ctr, 8'h80);
    repeat (20) @(posedge clk);
    #1;
    chk("midrst_no_rsp", rsp_seen - base_rsp, 0);

    chk("exp_q_drained", exp_q.size(), 0);
    chk("rsp_q_drained", rsp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
